ex_mem_stage: RTL

- Execute stage plus EX/MEM pipeline register for the 5-stage MIPS core.
- Consumes the registered ID/EX bundle (operands, register IDs, sign-extended immediate, jump field, control) and resolves operand forwarding.
- Performs the ALU operation, resolves branches and jumps, and issues a PC redirect.
- Registers the result bundle for the memory stage.

---
 rtl/core_pkg.sv | 35 +++
 rtl/alu32.sv | 24 ++
 rtl/ex_mem_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage MIPS core: widths, ALU and PC-source
// encodings, and the EX/MEM pipeline bundle.
package core_pkg;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BEQ = 2'b01;
  localparam logic [1:0] PCS_J   = 2'b10;
  localparam logic [1:0] PCS_JR  = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [RA_W-1:0]   dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_mem_t;

  // A later stage supplies the operand only if it writes a nonzero register matching idx.
  function automatic logic fwd_hit(input logic en, input logic [RA_W-1:0] dst,
                                   input logic [RA_W-1:0] idx);
    return en && (dst != '0) && (dst == idx);
  endfunction

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU: AND, OR, ADD, SUB, signed SLT; unknown codes give 0.
module alu32 import core_pkg::*; (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, branch/jump resolution and the
// EX/MEM pipeline register feeding the memory stage.
module ex_mem_stage import core_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [RA_W-1:0]   rs_i,
  input  logic [RA_W-1:0]   rt_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [25:0]       jaddr_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_dst_i,
  input  logic              alu_src_i,
  input  logic [2:0]        alu_ctrl_i,
  input  logic [1:0]        pc_src_i,
  input  logic              wb_reg_write_i,
  input  logic [RA_W-1:0]   wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              redirect_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [RA_W-1:0]   dest_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o
);

  ex_mem_t           ex_mem_d, ex_mem_q;
  logic [DATA_W-1:0] fwd_rs, fwd_rt, op_b, alu_y, target;
  logic              alu_zero, taken;

  // MEM-stage result wins over WB data when both match the same source register.
  always_comb begin
    fwd_rs = rs_data_i;
    if (fwd_hit(ex_mem_q.reg_write, ex_mem_q.dest, rs_i))
      fwd_rs = ex_mem_q.alu_result;
    else if (fwd_hit(wb_reg_write_i, wb_rd_i, rs_i))
      fwd_rs = wb_data_i;

    fwd_rt = rt_data_i;
    if (fwd_hit(ex_mem_q.reg_write, ex_mem_q.dest, rt_i))
      fwd_rt = ex_mem_q.alu_result;
    else if (fwd_hit(wb_reg_write_i, wb_rd_i, rt_i))
      fwd_rt = wb_data_i;
  end

  assign op_b = alu_src_i ? imm_i : fwd_rt;

  alu32 u_alu (
    .a      (fwd_rs),
    .b      (op_b),
    .ctrl   (alu_ctrl_i),
    .result (alu_y),
    .zero   (alu_zero)
  );

  always_comb begin
    target = '0;
    taken  = 1'b0;
    case (pc_src_i)
      PCS_BEQ: begin
        target = pc_plus4_i + (imm_i << 2);
        taken  = alu_zero;
      end
      PCS_J: begin
        target = {pc_plus4_i[31:28], jaddr_i, 2'b00};
        taken  = 1'b1;
      end
      PCS_JR: begin
        target = fwd_rs;
        taken  = 1'b1;
      end
      default: begin
        target = '0;
        taken  = 1'b0;
      end
    endcase
  end

  // A stalled or resetting stage must not steer fetch.
  assign redirect_o    = taken && !stall && !rst;
  assign redirect_pc_o = redirect_o ? target : '0;

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall) begin
      ex_mem_d.alu_result = alu_y;
      ex_mem_d.store_data = fwd_rt;
      ex_mem_d.dest       = reg_dst_i ? rd_i : rt_i;
      ex_mem_d.reg_write  = reg_write_i;
      ex_mem_d.mem_read   = mem_read_i;
      ex_mem_d.mem_write  = mem_write_i;
      ex_mem_d.mem_to_reg = mem_to_reg_i;
      if (flush) begin
        ex_mem_d.reg_write = 1'b0;
        ex_mem_d.mem_read  = 1'b0;
        ex_mem_d.mem_write = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_mem_q <= '0;
    else     ex_mem_q <= ex_mem_d;
  end

  assign alu_result_o = ex_mem_q.alu_result;
  assign store_data_o = ex_mem_q.store_data;
  assign dest_o       = ex_mem_q.dest;
  assign reg_write_o  = ex_mem_q.reg_write;
  assign mem_read_o   = ex_mem_q.mem_read;
  assign mem_write_o  = ex_mem_q.mem_write;
  assign mem_to_reg_o = ex_mem_q.mem_to_reg;

endmodule
